// File: rtl/id_pkg.sv
// id_pkg: shared default sizing for the ID-stage scoreboard
package id_pkg;
  localparam int DEF_REG_SZ = 32;
  localparam int DEF_NREG   = 32;
  localparam int DEF_NWB    = 2;
  localparam int DEF_NSRC   = 3;
  localparam int DEF_CNT_W  = 2;
  localparam int DEF_IDX_W  = $clog2(DEF_NREG);
endpackage

// File: rtl/sb_fwd_mux.sv
// sb_fwd_mux: per-source writeback bypass and readiness
module sb_fwd_mux
  import id_pkg::*;
#(
  parameter int REG_SZ = DEF_REG_SZ,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int NWB    = DEF_NWB
) (
  input  logic [IDX_W-1:0]      i_idx,
  input  logic                  i_use,
  input  logic [CNT_W-1:0]      i_cnt,
  input  logic [REG_SZ-1:0]     i_rval,
  input  logic [NWB-1:0]        i_wb_valid,
  input  logic [NWB*IDX_W-1:0]  i_wb_idx,
  input  logic [NWB*REG_SZ-1:0] i_wb_val,
  output logic                  o_ready,
  output logic [REG_SZ-1:0]     o_val
);
  logic              w_hit;
  logic [REG_SZ-1:0] w_fwd;
  // pick the highest-numbered valid writeback hitting this source, else the stored value
  always_comb begin
    w_hit = 1'b0;
    w_fwd = i_rval;
    for (int k = 0; k < NWB; k++)
      if (i_wb_valid[k] && i_wb_idx[k*IDX_W+:IDX_W] == i_idx) begin
        w_hit = 1'b1;
        w_fwd = i_wb_val[k*REG_SZ+:REG_SZ];
      end
  end
  assign o_val   = i_idx == '0 ? '0 : w_fwd;
  assign o_ready = !i_use || i_idx == '0 || i_cnt == '0 || (i_cnt == CNT_W'(1) && w_hit);
endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: register pending-writer tracking with writeback forwarding
module id_scoreboard
  import id_pkg::*;
#(
  parameter int REG_SZ = DEF_REG_SZ,
  parameter int NREG   = DEF_NREG,
  parameter int NWB    = DEF_NWB,
  parameter int NSRC   = DEF_NSRC,
  parameter int CNT_W  = DEF_CNT_W,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic [IDX_W-1:0]       iss_rd,
  input  logic                   iss_rd_we,
  input  logic [NSRC*IDX_W-1:0]  src_idx,
  input  logic [NSRC-1:0]        src_use,
  output logic [NSRC*REG_SZ-1:0] src_val,
  input  logic [NWB-1:0]         wb_valid,
  input  logic [NWB*IDX_W-1:0]   wb_idx,
  input  logic [NWB*REG_SZ-1:0]  wb_val,
  output logic [NREG-1:0]        busy,
  output logic                   err,
  output logic [15:0]            stall_cnt
);
  logic [CNT_W-1:0]  r_cnt [NREG];
  logic [REG_SZ-1:0] r_val [NREG];
  logic              r_err;
  logic [15:0]       r_stall;
  logic [CNT_W-1:0]  w_cnt_nx [NREG];
  logic [REG_SZ-1:0] w_val_nx [NREG];
  logic [NREG-1:0]   w_ue;
  logic [NSRC-1:0]   w_rdy;
  logic              w_fire;
  for (genvar j = 0; j < NSRC; j++) begin : g_src
    sb_fwd_mux #(.REG_SZ(REG_SZ), .IDX_W(IDX_W), .CNT_W(CNT_W), .NWB(NWB)) u_fwd (
      .i_idx      (src_idx[j*IDX_W+:IDX_W]),
      .i_use      (src_use[j]),
      .i_cnt      (r_cnt[src_idx[j*IDX_W+:IDX_W]]),
      .i_rval     (r_val[src_idx[j*IDX_W+:IDX_W]]),
      .i_wb_valid (wb_valid),
      .i_wb_idx   (wb_idx),
      .i_wb_val   (wb_val),
      .o_ready    (w_rdy[j]),
      .o_val      (src_val[j*REG_SZ+:REG_SZ])
    );
  end
  assign iss_ready = &w_rdy && !(iss_rd_we && iss_rd != '0 && r_cnt[iss_rd] == '1);
  assign w_fire    = iss_valid && iss_ready;
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic [CNT_W:0]    w_t;
    logic [CNT_W-1:0]  w_d;
    logic              w_u;
    logic [REG_SZ-1:0] w_v;
    // next count = count + issue - hits (floored); underflow when hits exceed the old count
    always_comb begin
      w_t = {1'b0, r_cnt[g]} + {{CNT_W{1'b0}}, w_fire && iss_rd_we && g != 0 && iss_rd == IDX_W'(g)};
      w_d = r_cnt[g];
      w_u = 1'b0;
      w_v = r_val[g];
      for (int k = 0; k < NWB; k++)
        if (g != 0 && wb_valid[k] && wb_idx[k*IDX_W+:IDX_W] == IDX_W'(g)) begin
          w_v = wb_val[k*REG_SZ+:REG_SZ];
          w_t = w_t == '0 ? w_t : w_t - (CNT_W+1)'(1);
          w_u = w_u | (w_d == '0);
          w_d = w_d == '0 ? w_d : w_d - CNT_W'(1);
        end
    end
    assign w_cnt_nx[g] = w_t[CNT_W-1:0];
    assign w_val_nx[g] = w_v;
    assign w_ue[g]     = w_u;
    assign busy[g]     = r_cnt[g] != '0;
  end
  // commit register state, sticky underflow flag and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
        r_val[r] <= '0;
      end
      r_err   <= 1'b0;
      r_stall <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= w_cnt_nx[r];
        r_val[r] <= w_val_nx[r];
      end
      r_err   <= r_err | (|w_ue);
      r_stall <= (iss_valid && !iss_ready && r_stall != 16'hFFFF) ? r_stall + 16'd1 : r_stall;
    end
  end
  assign err       = r_err;
  assign stall_cnt = r_stall;
endmodule
